// File: rtl/id_pkg.sv
// Shared decode constants and the EX-stage control bundle for the ID/EX pipeline stage.
package id_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [2:0] alu_control;
  } ex_ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational main + ALU decoder: opcode/funct to EX control bits, rd/rt select, illegal flag.
module id_decoder
  import id_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ex_ctrl_t   ctrl_o,
  output logic       reg_dst_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    reg_dst_o = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OpRtype: begin
        ctrl_o.reg_write = 1'b1;
        reg_dst_o        = 1'b1;
        case (funct_i)
          FnAdd:   ctrl_o.alu_control = AluAdd;
          FnSub:   ctrl_o.alu_control = AluSub;
          FnAnd:   ctrl_o.alu_control = AluAnd;
          FnOr:    ctrl_o.alu_control = AluOr;
          FnSlt:   ctrl_o.alu_control = AluSlt;
          default: begin
            ctrl_o    = '0;
            reg_dst_o = 1'b0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OpLw: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.mem_to_reg  = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = AluAdd;
      end
      OpSw: begin
        ctrl_o.mem_write   = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = AluAdd;
      end
      OpBeq: begin
        ctrl_o.branch      = 1'b1;
        ctrl_o.alu_control = AluSub;
      end
      OpAddi: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = AluAdd;
      end
      OpJ: begin
        ctrl_o.jump        = 1'b1;
        ctrl_o.alu_control = AluAdd;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with writeback bypass, load-use stall detection and the ID/EX pipeline register.
module id_ex_stage
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       InstrD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic              ValidD,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              FlushE,
  output logic [REG_AW-1:0] A1,
  output logic [REG_AW-1:0] A2,
  output logic              StallD,
  output logic              ValidE,
  output logic              IllegalE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] SrcAE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [DATA_W-1:0] SignImmE,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic [REG_AW-1:0] WriteRegE,
  output logic [DATA_W-1:0] PCPlus4E
);

  typedef struct packed {
    logic              valid;
    logic              illegal;
    ex_ctrl_t          ctrl;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] sign_imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] pc_plus4;
  } ex_reg_t;

  ex_reg_t           ex_d, ex_q;
  ex_ctrl_t          dec_ctrl;
  logic              dec_reg_dst;
  logic              dec_illegal;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] src_a, src_b;
  logic              unused_shamt;

  assign A1           = InstrD[25:21];
  assign A2           = InstrD[20:16];
  assign rd           = InstrD[15:11];
  assign unused_shamt = ^InstrD[10:6];

  id_decoder u_decoder (
    .op_i     (InstrD[31:26]),
    .funct_i  (InstrD[5:0]),
    .ctrl_o   (dec_ctrl),
    .reg_dst_o(dec_reg_dst),
    .illegal_o(dec_illegal)
  );

  // $0 always reads zero, even if writeback targets it.
  always_comb begin
    src_a = RD1;
    src_b = RD2;
    if (RegWriteW && (WriteRegW == A1)) src_a = ResultW;
    if (RegWriteW && (WriteRegW == A2)) src_b = ResultW;
    if (A1 == '0) src_a = '0;
    if (A2 == '0) src_b = '0;
  end

  assign StallD = ex_q.valid && ex_q.ctrl.mem_to_reg && (ex_q.rt != '0) &&
                  ((ex_q.rt == A1) || (ex_q.rt == A2));

  always_comb begin
    ex_d = '0;
    if (!FlushE && !StallD && ValidD) begin
      ex_d.valid      = 1'b1;
      ex_d.illegal    = dec_illegal;
      ex_d.ctrl       = dec_ctrl;
      ex_d.src_a      = src_a;
      ex_d.write_data = src_b;
      ex_d.sign_imm   = {{(DATA_W-16){InstrD[15]}}, InstrD[15:0]};
      ex_d.rs         = A1;
      ex_d.rt         = A2;
      // Non-writing instructions carry a zero destination.
      ex_d.write_reg  = dec_ctrl.reg_write ? (dec_reg_dst ? rd : A2) : '0;
      ex_d.pc_plus4   = PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ValidE      = ex_q.valid;
  assign IllegalE    = ex_q.illegal;
  assign RegWriteE   = ex_q.ctrl.reg_write;
  assign MemtoRegE   = ex_q.ctrl.mem_to_reg;
  assign MemWriteE   = ex_q.ctrl.mem_write;
  assign BranchE     = ex_q.ctrl.branch;
  assign JumpE       = ex_q.ctrl.jump;
  assign ALUSrcE     = ex_q.ctrl.alu_src;
  assign ALUControlE = ex_q.ctrl.alu_control;
  assign SrcAE       = ex_q.src_a;
  assign WriteDataE  = ex_q.write_data;
  assign SignImmE    = ex_q.sign_imm;
  assign RsE         = ex_q.rs;
  assign RtE         = ex_q.rt;
  assign WriteRegE   = ex_q.write_reg;
  assign PCPlus4E    = ex_q.pc_plus4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents queued at drive time, compared after the edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCPlus4D, RD1, RD2, ResultW;
  logic        ValidD, RegWriteW, FlushE;
  logic [4:0]  WriteRegW, A1, A2;
  logic        StallD, ValidE, IllegalE, RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] SrcAE, WriteDataE, SignImmE, PCPlus4E;
  logic [4:0]  RsE, RtE, WriteRegE;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RD1(RD1), .RD2(RD2), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .FlushE(FlushE), .A1(A1), .A2(A2), .StallD(StallD), .ValidE(ValidE), .IllegalE(IllegalE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .SrcAE(SrcAE),
    .WriteDataE(WriteDataE), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .PCPlus4E(PCPlus4E)
  );

  typedef struct packed {
    logic        valid, illegal, rw, m2r, mw, br, jmp, asrc;
    logic [2:0]  alu;
    logic [31:0] srca, wdata, imm;
    logic [4:0]  rs, rt, wr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  bit          have_state = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_stalls = 0;
  logic [31:0] pc = 32'h0000_1000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rd,
                                          input logic rww, input logic [4:0] wrw,
                                          input logic [31:0] resw);
    if (a == 5'd0) return 32'd0;
    if (rww && wrw == a) return resw;
    return rd;
  endfunction

  // Reference decode written from the instruction table, independent of the RTL structure.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc4,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic rww, input logic [4:0] wrw, input logic [31:0] resw);
    exp_t e = '0;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    e.valid = 1'b1;
    e.rs    = ins[25:21];
    e.rt    = ins[20:16];
    e.srca  = operand(ins[25:21], rd1, rww, wrw, resw);
    e.wdata = operand(ins[20:16], rd2, rww, wrw, resw);
    e.imm   = {{16{ins[15]}}, ins[15:0]};
    e.pc4   = pc4;
    if (op == 6'h00 && fn == 6'h20)      begin e.rw = 1; e.alu = 3'b010; e.wr = ins[15:11]; end
    else if (op == 6'h00 && fn == 6'h22) begin e.rw = 1; e.alu = 3'b110; e.wr = ins[15:11]; end
    else if (op == 6'h00 && fn == 6'h24) begin e.rw = 1; e.alu = 3'b000; e.wr = ins[15:11]; end
    else if (op == 6'h00 && fn == 6'h25) begin e.rw = 1; e.alu = 3'b001; e.wr = ins[15:11]; end
    else if (op == 6'h00 && fn == 6'h2A) begin e.rw = 1; e.alu = 3'b111; e.wr = ins[15:11]; end
    else if (op == 6'h23) begin e.rw = 1; e.m2r = 1; e.asrc = 1; e.alu = 3'b010; e.wr = ins[20:16]; end
    else if (op == 6'h2B) begin e.mw = 1; e.asrc = 1; e.alu = 3'b010; end
    else if (op == 6'h04) begin e.br = 1; e.alu = 3'b110; end
    else if (op == 6'h08) begin e.rw = 1; e.asrc = 1; e.alu = 3'b010; e.wr = ins[20:16]; end
    else if (op == 6'h02) begin e.jmp = 1; e.alu = 3'b010; end
    else e.illegal = 1'b1;
    return e;
  endfunction

  task automatic compare_ex(input exp_t e);
    check_eq("ValidE", ValidE, e.valid);
    check_eq("IllegalE", IllegalE, e.illegal);
    check_eq("RegWriteE", RegWriteE, e.rw);
    check_eq("MemtoRegE", MemtoRegE, e.m2r);
    check_eq("MemWriteE", MemWriteE, e.mw);
    check_eq("BranchE", BranchE, e.br);
    check_eq("JumpE", JumpE, e.jmp);
    check_eq("ALUSrcE", ALUSrcE, e.asrc);
    check_eq("ALUControlE", ALUControlE, e.alu);
    check_eq("SrcAE", SrcAE, e.srca);
    check_eq("WriteDataE", WriteDataE, e.wdata);
    check_eq("SignImmE", SignImmE, e.imm);
    check_eq("RsE", RsE, e.rs);
    check_eq("RtE", RtE, e.rt);
    check_eq("WriteRegE", WriteRegE, e.wr);
    check_eq("PCPlus4E", PCPlus4E, e.pc4);
  endtask

  // One cycle: drive, check combinational outputs, queue expectation, clock, pop and compare.
  task automatic step(input logic rst, input logic [31:0] ins, input logic vld, input logic fl,
                      input logic [31:0] rd1, input logic [31:0] rd2, input logic rww,
                      input logic [4:0] wrw, input logic [31:0] resw);
    logic exp_stall;
    exp_t e;
    pc = pc + 32'd4;
    reset = rst; InstrD = ins; ValidD = vld; FlushE = fl; PCPlus4D = pc;
    RD1 = rd1; RD2 = rd2; RegWriteW = rww; WriteRegW = wrw; ResultW = resw;
    #1;
    exp_stall = 1'b0;
    if (have_state) begin
      exp_stall = cur.valid && cur.m2r && cur.rt != 5'd0 &&
                  (cur.rt == ins[25:21] || cur.rt == ins[20:16]);
      check_eq("StallD", StallD, exp_stall);
    end
    check_eq("A1", A1, ins[25:21]);
    check_eq("A2", A2, ins[20:16]);
    if (rst || fl || exp_stall || !vld) sb_q.push_back('0);
    else sb_q.push_back(model(ins, pc, rd1, rd2, rww, wrw, resw));
    @(posedge clk);
    #1;
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      compare_ex(e);
      cur = e;
      have_state = 1;
    end
  endtask

  localparam logic [31:0] LwI   = 32'h8C22_0004; // lw $2,4($1)
  localparam logic [31:0] AddU  = 32'h0044_1820; // add $3,$2,$4
  localparam logic [31:0] AddI  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] Add0  = 32'h0002_1820; // add $3,$0,$2
  localparam logic [31:0] AddiI = 32'h2005_FFFF; // addi $5,$0,-1

  initial begin
    logic [31:0] tmpl [8];
    logic [31:0] ins;
    tmpl = '{32'h0000_0020, 32'h0000_0022, 32'h0000_0024, 32'h0000_0025, 32'h0000_002A,
             32'h8C00_0000, 32'hAC00_0000, 32'h1000_0000};

    step(1, LwI, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0);
    step(1, LwI, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0);
    step(0, AddI, 1, 0, 32'd5, 32'd7, 0, 5'd0, 32'd0);
    step(0, AddI, 1, 0, 32'd0, 32'd7, 1, 5'd1, 32'hDEAD_BEEF);
    step(0, Add0, 1, 0, 32'h1234, 32'd7, 1, 5'd0, 32'hDEAD_BEEF);
    step(0, 32'h0022_1822, 1, 0, 32'd9, 32'd3, 1, 5'd2, 32'h55); // sub, bypass on B
    step(0, 32'h0022_1824, 1, 0, 32'hF0, 32'h3C, 0, 5'd0, 32'd0);
    step(0, 32'h0022_1825, 1, 0, 32'hF0, 32'h3C, 0, 5'd0, 32'd0);
    step(0, 32'h0022_182A, 1, 0, 32'hF0, 32'h3C, 0, 5'd0, 32'd0);
    // Load-use: stall, bubble, then the held add issues.
    step(0, LwI, 1, 0, 32'd100, 32'd0, 0, 5'd0, 32'd0);
    step(0, AddU, 1, 0, 32'd11, 32'd22, 0, 5'd0, 32'd0);
    check_eq("stall_bubble", ValidE, 1'b0);
    step(0, AddU, 1, 0, 32'd11, 32'd22, 0, 5'd0, 32'd0);
    check_eq("add_after_stall", ValidE, 1'b1);
    step(0, AddiI, 1, 0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, AddiI, 1, 1, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    step(0, 32'hFC00_0000, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0); // opcode 0x3F
    step(0, 32'h0022_1800, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0); // R-type bad funct
    step(0, 32'hAC22_0008, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0); // sw
    step(0, 32'h1022_FFFE, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0); // beq
    step(0, 32'h0800_0040, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0); // j
    step(0, AddI, 0, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0);          // ValidD=0
    // Reset during a stall drops the stalled add; it issues fresh afterwards.
    step(0, LwI, 1, 0, 32'd1, 32'd0, 0, 5'd0, 32'd0);
    step(1, AddU, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0);
    step(0, AddU, 1, 0, 32'd1, 32'd2, 0, 5'd0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      ins = tmpl[$urandom_range(0, 7)];
      ins[25:21] = 5'($urandom_range(0, 4));
      ins[20:16] = 5'($urandom_range(0, 4));
      ins[15:11] = 5'($urandom_range(0, 7));
      if (ins[31:26] != 6'h00) ins[15:0] = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ins[31:26] = 6'h08;
      step(0, ins, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), $urandom, $urandom,
           1'($urandom), 5'($urandom_range(0, 4)), $urandom);
      if (StallD) n_stalls++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
